// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared types and default sizing for the serial scan controller.
//   state_e : controller states (IDLE=1'b0, SHIFT=1'b1)
//   DEF_DW  : default input word width
//   DEF_PW  : default pattern length
//   DEF_CW  : default hit counter width
package seq_scan_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_PW = 4;
    localparam int unsigned DEF_CW = 8;

endpackage

// File: rtl/seq_scan_match.sv
// seq_scan_match: sliding-window pattern matcher with saturating hit counter.
//   i_clk       : clock, rising edge
//   i_rstn      : synchronous active-low reset
//   i_clr       : clears window, fill count, pending hit and counter
//   i_bit       : serial bit
//   i_bit_vld   : i_bit valid this cycle
//   i_pattern   : pattern that belongs to i_bit (captured with the bit)
//   i_overlap   : overlap mode that belongs to i_bit (captured with the bit)
//   o_hit       : one-cycle pulse per match
//   o_hit_cnt   : saturating count of hits
module seq_scan_match
    import seq_scan_pkg::*;
#(
    parameter int unsigned PW = DEF_PW,
    parameter int unsigned CW = DEF_CW
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_clr,
    input  logic          i_bit,
    input  logic          i_bit_vld,
    input  logic [PW-1:0] i_pattern,
    input  logic          i_overlap,
    output logic          o_hit,
    output logic [CW-1:0] o_hit_cnt
);

    localparam int unsigned FW = $clog2(PW + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PW);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    logic [PW-1:0] r_win;
    logic [FW-1:0] r_fill;
    logic          r_upd;      // window took a new bit on the previous edge
    logic [PW-1:0] r_pat;      // pattern travelling with the newest window bit
    logic          r_ovl;
    logic          r_hit;
    logic [CW-1:0] r_cnt;

    logic          w_match;

    // Evaluated only once per window update so a static window never re-fires
    assign w_match = r_upd && (r_fill == FILL_FULL) && (r_win == r_pat);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_win  <= '0;
            r_fill <= '0;
            r_upd  <= 1'b0;
            r_pat  <= '0;
            r_ovl  <= 1'b0;
            r_hit  <= 1'b0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            // Drops the incoming bit and any hit pending this cycle
            r_win  <= '0;
            r_fill <= '0;
            r_upd  <= 1'b0;
            r_hit  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_upd <= i_bit_vld;
            r_hit <= w_match;

            if (w_match && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (i_bit_vld) begin
                r_win <= {r_win[PW-2:0], i_bit};
                r_pat <= i_pattern;
                r_ovl <= i_overlap;
            end

            // Non-overlap restarts the fill; a bit arriving on the same edge
            // is the first fresh bit of the next candidate
            if (w_match && !r_ovl) begin
                r_fill <= i_bit_vld ? FW'(1) : '0;
            end else if (i_bit_vld && (r_fill != FILL_FULL)) begin
                r_fill <= r_fill + FW'(1);
            end
        end
    end

    assign o_hit     = r_hit;
    assign o_hit_cnt = r_cnt;

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts words over valid/ready, serializes them MSB-first
// into a continuous bit stream and scans it for a programmable pattern.
//   i_clk, i_rstn : clock / synchronous active-low reset
//   i_data, i_valid, o_ready : word input handshake
//   i_pattern, i_overlap     : scan configuration, captured on acceptance
//   i_clr                    : clears hit counter and match history
//   o_ser_bit, o_ser_vld     : serial stream
//   o_hit, o_hit_cnt         : match pulse and saturating match count
//   o_busy, o_done           : word in flight / end-of-word pulse
// Optional (macro SEQ_SCAN_IRQ_EN): o_irq sticky hit interrupt, i_irq_ack.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned PW = DEF_PW,
    parameter int unsigned CW = DEF_CW
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_pattern,
    input  logic          i_overlap,
    input  logic          i_clr,
    output logic          o_ser_bit,
    output logic          o_ser_vld,
    output logic          o_hit,
    output logic [CW-1:0] o_hit_cnt,
    output logic          o_busy,
    output logic          o_done
`ifdef SEQ_SCAN_IRQ_EN
    ,
    output logic          o_irq,
    input  logic          i_irq_ack
`endif
);

    localparam int unsigned BCW = $clog2(DW);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

    state_e        r_state;
    logic [DW-1:0] r_shreg;
    logic [BCW-1:0] r_bitcnt;
    logic [PW-1:0] r_pat;
    logic          r_ovl;
    logic          r_ser_bit;
    logic          r_ser_vld;
    logic [PW-1:0] r_ser_pat;   // pattern of the word the launched bit came from
    logic          r_ser_ovl;
    logic          r_last;      // last bit of a word launched on the previous edge
    logic          r_done;

    logic          w_ready;
    logic          w_hit;
    logic [CW-1:0] w_hit_cnt;

    // Ready in IDLE and in the cycle launching the final bit (zero-bubble reload)
    assign w_ready = (r_state == IDLE) || ((r_state == SHIFT) && (r_bitcnt == LAST_BIT));

    // Handshake, shift register and bit counter
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_pat     <= '0;
            r_ovl     <= 1'b0;
            r_ser_bit <= 1'b0;
            r_ser_vld <= 1'b0;
            r_ser_pat <= '0;
            r_ser_ovl <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ser_bit <= 1'b0;
            r_ser_vld <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= r_last;

            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_shreg  <= i_data;
                        r_pat    <= i_pattern;
                        r_ovl    <= i_overlap;
                        r_bitcnt <= '0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_ser_bit <= r_shreg[DW-1];
                    r_ser_vld <= 1'b1;
                    r_ser_pat <= r_pat;
                    r_ser_ovl <= r_ovl;
                    r_shreg   <= {r_shreg[DW-2:0], 1'b0};
                    r_bitcnt  <= r_bitcnt + BCW'(1);
                    if (r_bitcnt == LAST_BIT) begin
                        r_last <= 1'b1;
                        if (i_valid) begin
                            r_shreg  <= i_data;
                            r_pat    <= i_pattern;
                            r_ovl    <= i_overlap;
                            r_bitcnt <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    seq_scan_match #(
        .PW (PW),
        .CW (CW)
    ) u_match (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_clr     (i_clr),
        .i_bit     (r_ser_bit),
        .i_bit_vld (r_ser_vld),
        .i_pattern (r_ser_pat),
        .i_overlap (r_ser_ovl),
        .o_hit     (w_hit),
        .o_hit_cnt (w_hit_cnt)
    );

`ifdef SEQ_SCAN_IRQ_EN
    logic r_irq;

    // Sticky interrupt; acknowledge wins over a coincident hit
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_irq <= 1'b0;
        end else if (i_irq_ack) begin
            r_irq <= 1'b0;
        end else if (w_hit) begin
            r_irq <= 1'b1;
        end
    end

    assign o_irq = r_irq;
`endif

    assign o_ready   = w_ready;
    assign o_ser_bit = r_ser_bit;
    assign o_ser_vld = r_ser_vld;
    assign o_hit     = w_hit;
    assign o_hit_cnt = w_hit_cnt;
    assign o_busy    = (r_state == SHIFT) || r_ser_vld;
    assign o_done    = r_done;

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Controller that accepts parallel words over a valid/ready handshake and serializes them MSB-first into a continuous bit stream. It scans that stream for a programmable PW-bit pattern, with overlapping or non-overlapping matching, and counts hits in a saturating counter. It generalizes the fixed serial pattern detectors to a host-configurable scan engine sitting between a word source and the detection/status logic.

Parameters:
- DW, 8: input word width (>=2)
- PW, 4: pattern length in bits (2..DW)
- CW, 8: hit counter width

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rstn  input  1  synchronous active-low reset
- i_data  input  DW  word to serialize
- i_valid  input  1  i_data valid
- o_ready  output  1  controller can accept a word this cycle
- i_pattern  input  PW  pattern, sampled on each word acceptance
- i_overlap  input  1  1 = overlapping matches, sampled on acceptance
- i_clr  input  1  clears hit counter and match history
- o_ser_bit  output  1  serialized bit
- o_ser_vld  output  1  o_ser_bit valid
- o_hit  output  1  one-cycle pulse per pattern match
- o_hit_cnt  output  CW  saturating hit count
- o_busy  output  1  word in flight
- o_done  output  1  one-cycle pulse after last bit of each word

Behaviour:
- Clock and reset: single clock i_clk; reset i_rstn is synchronous and active-low.
- Reset values: state=IDLE; o_ready=1 (combinational from state); all other outputs 0; shift register, bit counter, window, fill count and counter cleared.
- Reset mid-operation aborts the word. The partial stream is discarded and no o_done is issued.
- FSM states: IDLE, SHIFT.
  - IDLE: o_ready=1. On i_valid&&o_ready, load i_data, i_pattern and i_overlap, clear bit counter, go to SHIFT.
  - SHIFT: each cycle register o_ser_bit=shreg[DW-1] and o_ser_vld=1, shift left, increment bit counter.
  - o_ready=1 also in the SHIFT cycle that launches bit DW-1.
  - Handshake in that cycle: reload and stay in SHIFT, giving zero-bubble back-to-back words.
  - No handshake in that cycle: go to IDLE.
- o_busy=1 whenever state=SHIFT or o_ser_vld=1.
- Latency: word accepted at edge N gives its first o_ser_vld at cycle N+1. DW consecutive o_ser_vld cycles follow.
- o_done pulses in the cycle after the last bit's o_ser_vld cycle. It also pulses for each back-to-back word.
- Window: on o_ser_vld, win <= {win[PW-2:0], o_ser_bit}; fill count increments and saturates at PW.
- Match: when fill count==PW and win==active pattern, o_hit=1 one cycle after the window update (registered, Moore-style).
- The window persists across word boundaries, so matches may span words.
- Non-overlap mode (i_overlap=0): a hit resets the fill count to 0, so the next match needs PW fresh bits.
- Overlap mode: fill count stays at PW after a hit.
- o_hit_cnt increments on each o_hit pulse and saturates at 2^CW-1, no wrap.
- i_clr, synchronous, highest priority after reset:
  - clears counter, window and fill count;
  - a hit pending in the same cycle is dropped;
  - serialization is unaffected.
- A pattern change takes effect only at the next word acceptance. It never applies mid-word.
- i_valid while o_ready=0: ignored; the source must hold i_data.

Optional Feature:
- Macro SEQ_SCAN_IRQ_EN.
- Defined: adds ports o_irq (output, 1) and i_irq_ack (input, 1).
  - o_irq is sticky: set the cycle after o_hit, cleared by i_irq_ack (ack wins on a simultaneous hit), reset 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include seq_scan_pkg: state encodings (IDLE=1'b0, SHIFT=1'b1) and default DW/PW/CW constants.
- Sub-module seq_scan_match, instantiated once, containing:
  - window and fill counter;
  - pattern compare;
  - overlap handling;
  - saturating hit counter;
  - i_clr handling.
- Top level keeps the handshake, shift register and bit counter.

Test Plan:
- Overlap: PW=4, pattern 4'b1010, overlap=1, word 8'b1010_1010 -> o_hit after bits 4, 6, 8; o_hit_cnt=3; one o_done.
- Non-overlap: same stimulus with overlap=0 -> hits after bits 4 and 8; o_hit_cnt=2.
- Cross-word: pattern 4'b1011, words 8'h05 then 8'h80 held valid back-to-back -> 16 contiguous o_ser_vld cycles, no bubble; exactly one hit, on the first bit of word 2; two o_done pulses.
- Saturation: CW=2, pattern 4'b1111, overlap=1, word 8'hFF -> 5 o_hit pulses; o_hit_cnt stops at 3. Then i_clr -> o_hit_cnt=0 next cycle.
- Reset mid-shift: i_rstn=0 for one edge after 3 bits of 8'hA5 -> next cycle all outputs 0 except o_ready=1; no o_done; new word accepted normally.
- IRQ (SEQ_SCAN_IRQ_EN defined): hit -> o_irq=1 held; i_irq_ack=1 -> o_irq=0 next cycle; ack coincident with a new hit -> o_irq=0.
